gfx_wbm_rw_ctrl: RTL
====================

GFX_WBM_RW_CTRL -- requirements
Module: gfx_wbm_rw_ctrl

Interface
REQ-001 SHALL have parameter MDW, default 256: wishbone data width in bits, power of two, at least 32.
REQ-002 SHALL have parameter TMO_CYC, default 1023: bus cycles to wait for ack/err before timeout, range 1..65535.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the polarity and synchronicity are fixed.
REQ-004 clk_i  input  1  clock; all state changes on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 read_request_i  input  1  level read request from the GFX read/write arbiter.
REQ-007 write_request_i  input  1  level write request from the arbiter.
REQ-008 addr_i  input  32  byte address of the request.
REQ-009 sel_i  input  MDW/8  byte lane selects.
REQ-010 wdat_i  input  MDW  write data.
REQ-011 rdat_o  output  MDW  read data, valid while ack_o=1 and held until the next read completes.
REQ-012 ack_o  output  1  one-cycle completion pulse to the arbiter.
REQ-013 err_o  output  1  one-cycle pulse coincident with ack_o on bus error or timeout.
REQ-014 busy_o  output  1  high whenever the state is not IDLE.
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  wishbone cycle, strobe and write enable.
REQ-016 wbm_adr_o  output  32  wishbone address; wbm_sel_o  output  MDW/8; wbm_dat_o  output  MDW.
REQ-017 wbm_dat_i  input  MDW; wbm_ack_i  input  1; wbm_err_i  input  1  wishbone slave responses.

Function
REQ-018 SHALL implement the states IDLE, ACTIVE and DONE.
REQ-019 IDLE with read_request_i or write_request_i high: latch the request at the edge and enter ACTIVE.
- Latched fields: addr, sel, wdat, and we = write_request_i; write wins when both requests are high.
REQ-020 wbm_adr_o SHALL equal the latched address with the low log2(MDW/8) bits forced to 0.
REQ-021 In ACTIVE: wbm_cyc_o = wbm_stb_o = 1; wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o come from the latches and are stable for the whole cycle.
REQ-022 wbm_ack_i high in ACTIVE: go to DONE. If the access is a read, capture wbm_dat_i into rdat_o at the same edge.
REQ-023 wbm_err_i high in ACTIVE: go to DONE with err_o=1 in DONE; rdat_o is unchanged. err wins if ack and err arrive together.
REQ-024 Timeout counter:
- cleared on entry to ACTIVE and incremented each ACTIVE cycle without ack/err;
- when it reaches TMO_CYC, go to DONE with err_o=1; rdat_o is unchanged.
REQ-025 Wishbone outputs SHALL be 0 in IDLE and DONE; cyc/stb drop at the edge that leaves ACTIVE.
REQ-026 DONE SHALL last exactly one cycle with ack_o=1, then return to IDLE; requests are not sampled in DONE.
REQ-027 Latency: ack_o asserts exactly one cycle after the cycle in which wbm_ack_i/wbm_err_i is sampled high. Minimum request-to-ack_o latency is 3 cycles (IDLE, ACTIVE, DONE).
REQ-028 A request deasserted while ACTIVE SHALL NOT abort the bus cycle; it completes and ack_o still pulses.
REQ-029 Requester handshake: requests are held until ack_o, then deasserted or changed at the following edge; back-to-back requests are therefore spaced by one IDLE cycle.
REQ-030 wbm_ack_i/wbm_err_i received in IDLE or DONE SHALL be ignored.

Reset
REQ-031 With rst_ni=0, the following SHALL hold immediately and asynchronously:
- state=IDLE;
- ack_o, err_o, busy_o, wbm_cyc_o, wbm_stb_o and wbm_we_o = 0;
- wbm_adr_o, wbm_sel_o, wbm_dat_o and rdat_o = 0;
- timeout counter = 0.
REQ-032 Reset asserted mid-ACTIVE SHALL drop cyc/stb immediately, with no ack_o pulse after release.
REQ-033 The first request SHALL be sampled at the first rising edge with rst_ni=1.

Verification
REQ-034 Read: addr_i=0x0000_1234, sel all ones, slave acks after 2 wait cycles with data 0xA5..A5.
- wbm_adr_o=0x0000_1220 (MDW=256); cyc high 3 cycles;
- ack_o one cycle later with rdat_o=0xA5..A5; err_o=0.
REQ-035 Write: write_request_i with wdat_i=0x1111..11 and zero-wait ack -> wbm_we_o=1 and wbm_dat_o=0x1111..11 for 1 cycle; ack_o pulse; rdat_o unchanged.
REQ-036 Both requests high -> wbm_we_o=1. Slave asserts ack and err together -> ack_o=1 and err_o=1 in the same cycle.
REQ-037 TMO_CYC=4 with no slave response -> cyc drops after exactly 4 ACTIVE cycles, then ack_o=err_o=1 for one cycle.
REQ-038 Read request dropped one cycle after ACTIVE entry; slave acks 5 cycles later -> bus cycle completes and ack_o pulses.
REQ-039 rst_ni pulsed low mid-ACTIVE -> cyc/stb=0 asynchronously. After release, a late wbm_ack_i is ignored and no ack_o occurs.

Source files
------------

// File: rtl/gfx_wbm_rw_ctrl.sv
// Wishbone master for the GFX read/write arbiter: one bus cycle per request,
// with a bus timeout and a one-cycle ack_o/err_o completion pulse.
module gfx_wbm_rw_ctrl #(
    parameter int MDW     = 256,
    parameter int TMO_CYC = 1023
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               read_request_i,
    input  logic               write_request_i,
    input  logic [31:0]        addr_i,
    input  logic [MDW/8-1:0]   sel_i,
    input  logic [MDW-1:0]     wdat_i,
    output logic [MDW-1:0]     rdat_o,
    output logic               ack_o,
    output logic               err_o,
    output logic               busy_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [31:0]        wbm_adr_o,
    output logic [MDW/8-1:0]   wbm_sel_o,
    output logic [MDW-1:0]     wbm_dat_o,
    input  logic [MDW-1:0]     wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i
);
    localparam int SW = MDW / 8;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t          r_state, w_next;
    logic            r_we, r_err;
    logic [31:0]     r_adr;
    logic [SW-1:0]   r_sel;
    logic [MDW-1:0]  r_wdat, r_rdat;
    logic [15:0]     r_cnt;
    logic            w_req, w_tmo, w_act;

    assign w_req = read_request_i | write_request_i;
    // Last permitted ACTIVE cycle: the counter reaches TMO_CYC at this edge.
    assign w_tmo = (r_cnt == 16'(TMO_CYC - 1));
    assign w_act = (r_state == S_ACTIVE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req) w_next = S_ACTIVE;
            S_ACTIVE: if (wbm_ack_i || wbm_err_i || w_tmo) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we   <= 1'b0;
            r_err  <= 1'b0;
            r_adr  <= '0;
            r_sel  <= '0;
            r_wdat <= '0;
            r_rdat <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_we   <= write_request_i;
                    r_adr  <= addr_i & ~32'(SW - 1);
                    r_sel  <= sel_i;
                    r_wdat <= wdat_i;
                    r_cnt  <= '0;
                    r_err  <= 1'b0;
                end
                S_ACTIVE: begin
                    // err beats a simultaneous ack and leaves rdat untouched
                    if (wbm_err_i) begin
                        r_err <= 1'b1;
                    end else if (wbm_ack_i) begin
                        if (!r_we) r_rdat <= wbm_dat_i;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        if (w_tmo) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wbm_cyc_o = w_act;
    assign wbm_stb_o = w_act;
    assign wbm_we_o  = w_act & r_we;
    assign wbm_adr_o = w_act ? r_adr  : '0;
    assign wbm_sel_o = w_act ? r_sel  : '0;
    assign wbm_dat_o = w_act ? r_wdat : '0;
    assign ack_o     = (r_state == S_DONE);
    assign err_o     = (r_state == S_DONE) & r_err;
    assign busy_o    = (r_state != S_IDLE);
    assign rdat_o    = r_rdat;
endmodule
